bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Iterative BCD-to-binary converter: the reverse-double-dabble counterpart of `double_dabble`. It accepts a packed BCD word on a start strobe and shifts one bit per cycle, applying subtract-3 correction to each digit. It returns the binary value with range and digit-validity flags. It sits on the posit text-input path, turning decimal operands into integers before they are packed into posit fields.

## Interface
- `DIGITS`, 10, number of BCD digits in the input (input width 4*DIGITS)
- `BIN_W`, 32, width of the binary result

- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low
- `start`  in  1  conversion request, sampled only in IDLE or DONE
- `bcd`  in  4*DIGITS  packed BCD input; digit 0 in bits [3:0]; sampled on the accepting edge only
- `bin`  out  BIN_W  converted result; updated only on completion
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  high from completion until the next accepted `start` or reset
- `overflow`  out  1  result exceeds 2^BIN_W-1; `bin` holds the value mod 2^BIN_W
- `invalid`  out  1  some input nibble was > 9; `bin` is forced to 0

## Operation
- Reset values (while `reset` is low): state IDLE, `bin`=0, `busy`=0, `done`=0, `overflow`=0, `invalid`=0. Shift registers and the counter are cleared.
- States:
  - IDLE: `start`=1 moves to CONV.
  - CONV: runs exactly 4*DIGITS iterations, then moves to DONE.
  - DONE: `start`=1 moves to CONV; otherwise stays in DONE.
- Accept edge (IDLE or DONE with `start`=1):
  - load `bcd` into the BCD shift register `s`;
  - clear the 4*DIGITS-bit accumulator `acc`;
  - compute `inv` = any nibble of `bcd` > 9, and latch it internally;
  - set iteration counter to 0; `busy`=1; `done`=0.
- Each CONV cycle:
  - shift `s` right by one; the shifted-out LSB enters the MSB of `acc`, and `acc` shifts right;
  - then, in every digit of the shifted `s`, subtract 3 from any nibble >= 8;
  - increment the counter.
- Completion (the iteration with counter = 4*DIGITS-1):
  - `bin` = `acc`[BIN_W-1:0], or 0 if `inv`;
  - `overflow` = |`acc`[4*DIGITS-1:BIN_W] and not `inv`; `overflow` is 0 when BIN_W >= 4*DIGITS;
  - `invalid` = `inv`; `busy`=0; `done`=1.
- `start` during CONV is ignored; the captured operand is unaffected.
- `bin`, `overflow` and `invalid` keep their previous values throughout a conversion. They change only on the completion edge, or on reset.
- Accept in DONE: `done` falls on the accept edge; `bin` and flags still hold the old result until the new completion.
- Arithmetic: all corrections are unsigned 4-bit. Nibbles of a valid input never underflow. Behaviour with invalid nibbles is don't-care internally; only the forced outputs are specified.

## Timing
- Latency: accept at edge A; `done`=1 and `bin` valid after edge A+4*DIGITS (40 cycles at default). Edges A+1 through A+4*DIGITS are CONV.
- `busy` is high after edges A through A+4*DIGITS-1, and low after the completion edge.
- Back-to-back: `start` held high in DONE re-accepts on the very next edge, giving a throughput of 4*DIGITS+1 cycles per conversion.
- Reset asserted mid-conversion: outputs clear asynchronously with no completion. After release, the block is in IDLE and waits for a fresh `start`.
- Counter width is clog2(4*DIGITS); at the default that is 6 bits, with no wrap within a conversion.

## Test plan
- Reset, then `bcd`=40'h0001234567 with a one-cycle `start`:
  - exactly 40 cycles later `done`=1, `bin`=32'h0012D687, `overflow`=0, `invalid`=0;
  - `busy` is high for exactly 40 cycles.
- `bcd`=40'h4294967295 -> `bin`=32'hFFFFFFFF, `overflow`=0. `bcd`=40'h9999999999 -> `bin`=32'h540BE3FF, `overflow`=1.
- `bcd`=40'h00000000A0 -> `invalid`=1, `bin`=0, `overflow`=0. A following `bcd`=40'h0 conversion returns `invalid`=0, `bin`=0.
- Pulse `start` with `bcd`=40'h0000000123; 5 cycles later pulse `start` with 40'h0000000999:
  - the result is `bin`=123;
  - `bin` keeps its prior value until completion.
- Hold `start` high with `bcd`=40'h0000000042:
  - conversions repeat every 41 cycles;
  - `done` drops for exactly 40 cycles each time; `bin`=42.
- Assert `reset` low at cycle 20 of a conversion:
  - all outputs are 0 immediately;
  - after release, no `done` appears until a new `start`, which then converts correctly.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: start/operand request and result/status bundle for bcd_to_bin
interface bcd_to_bin_if #(parameter int DIGITS = 10, parameter int BIN_W = 32);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  invalid;
    modport master (output start, bcd, input bin, busy, done, overflow, invalid);
    modport slave  (input start, bcd, output bin, busy, done, overflow, invalid);
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative reverse-double-dabble BCD to binary converter
module bcd_to_bin #(
    parameter int DIGITS = 10,
    parameter int BIN_W  = 32
) (
    input logic          clock,
    input logic          reset,
    bcd_to_bin_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t           r_state;
    logic [W-1:0]     r_s, r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_inv, r_busy, r_done, r_ovf, r_invalid;
    logic [BIN_W-1:0] r_bin;
    logic [W-1:0]     w_sh, w_fix, w_acc;
    logic             w_inv;
    assign w_sh  = r_s >> 1;
    assign w_acc = {r_s[0], r_acc[W-1:1]};
    for (genvar d = 0; d < DIGITS; d++) begin : g_fix
        assign w_fix[4*d+:4] = (w_sh[4*d+:4] >= 4'd8) ? w_sh[4*d+:4] - 4'd3 : w_sh[4*d+:4];
    end
    always_comb begin
        w_inv = 1'b0;
        for (int i = 0; i < DIGITS; i++) w_inv = w_inv | (bus.bcd[4*i+:4] > 4'd9);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_s       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_inv     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bin     <= '0;
            r_ovf     <= 1'b0;
            r_invalid <= 1'b0;
        end else if (r_state != CONV) begin
            if (bus.start) begin
                r_state <= CONV;
                r_s     <= bus.bcd;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_inv   <= w_inv;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end
        end else begin
            r_s   <= w_fix;
            r_acc <= w_acc;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(W - 1)) begin
                r_state   <= DONE;
                r_bin     <= r_inv ? '0 : BIN_W'(w_acc);
                r_ovf     <= !r_inv && (|(w_acc >> BIN_W));
                r_invalid <= r_inv;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end
    assign bus.bin      = r_bin;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_ovf;
    assign bus.invalid  = r_invalid;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table, random and corner-sequence checks of bcd_to_bin
module tb_bcd_to_bin;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    bcd_to_bin_if #(.DIGITS(10), .BIN_W(32)) bus ();
    bcd_to_bin #(.DIGITS(10), .BIN_W(32)) dut (.clock(clk), .reset(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] bcd;
        logic [31:0] bin;
        logic        ovf;
        logic        inv;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal value of the digits, reduced to the 32-bit result and flags
    task automatic model(input logic [39:0] b, output logic [31:0] eb, output logic eo, output logic ei);
        longint unsigned v = 0;
        logic [3:0] n;
        ei = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            n = b[4*i+:4];
            if (n > 4'd9) ei = 1'b1;
            v = v * 10 + longint'(n);
        end
        eb = ei ? 32'd0 : v[31:0];
        eo = !ei && (v > 64'hFFFF_FFFF);
    endtask

    task automatic convert(input logic [39:0] b, input string name);
        int n = 0;
        logic bad_busy = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({name, " done_low_after_accept"}, 64'(bus.done), 64'd0);
        while (!bus.done && n < 100) begin
            if (!bus.busy) bad_busy = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'd40);
        chk({name, " busy_held"}, 64'(bad_busy), 64'd0);
        chk({name, " busy_low_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic conv_check(input logic [39:0] b, input string name);
        logic [31:0] eb;
        logic eo, ei;
        model(b, eb, eo, ei);
        convert(b, name);
        chk({name, " bin"}, 64'(bus.bin), 64'(eb));
        chk({name, " overflow"}, 64'(bus.overflow), 64'(eo));
        chk({name, " invalid"}, 64'(bus.invalid), 64'(ei));
    endtask

    initial begin
        vec_t tbl[8];
        logic [39:0] rb;
        logic [31:0] prev;
        logic [31:0] eb;
        logic eo, ei;
        int bad;
        tbl[0] = '{40'h0001234567, 32'h0012D687, 1'b0, 1'b0};
        tbl[1] = '{40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[2] = '{40'h9999999999, 32'h540BE3FF, 1'b1, 1'b0};
        tbl[3] = '{40'h00000000A0, 32'h00000000, 1'b0, 1'b1};
        tbl[4] = '{40'h0000000000, 32'h00000000, 1'b0, 1'b0};
        tbl[5] = '{40'h0000000042, 32'h0000002A, 1'b0, 1'b0};
        tbl[6] = '{40'h4294967296, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{40'hF000000001, 32'h00000000, 1'b0, 1'b1};
        bus.start = 1'b0;
        bus.bcd = '0;
        #12;
        chk("reset bin", 64'(bus.bin), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset flags", 64'({bus.overflow, bus.invalid}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].bcd, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d bin", i), 64'(bus.bin), 64'(tbl[i].bin));
            chk($sformatf("tbl%0d overflow", i), 64'(bus.overflow), 64'(tbl[i].ovf));
            chk($sformatf("tbl%0d invalid", i), 64'(bus.invalid), 64'(tbl[i].inv));
        end

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 10; i++)
                rb[4*i+:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            conv_check(rb, $sformatf("rand%0d", k));
        end

        // start during CONV is ignored and old result holds until completion
        prev = bus.bin;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd = 40'h0000000123;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin bus.start = 1'b1; bus.bcd = 40'h0000000999; end
            if (n == 6) bus.start = 1'b0;
            if (n < 40 && (bus.bin !== prev || bus.done !== 1'b0)) bad++;
            @(posedge clk); #1;
        end
        chk("ignore hold_prior", 64'(bad), 64'd0);
        chk("ignore done", 64'(bus.done), 64'd1);
        chk("ignore bin", 64'(bus.bin), 64'd123);

        // start held high: re-accept every 41 cycles
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd = 40'h0000000042;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 1; k <= 123; k++) begin
            @(posedge clk); #1;
            if (bus.done !== (k % 41 == 40)) bad++;
            if (k % 41 == 40 && bus.bin !== 32'd42) bad++;
        end
        bus.start = 1'b0;
        chk("b2b pattern", 64'(bad), 64'd0);
        @(posedge clk); #1;

        // async reset mid conversion
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd = 40'h0000000777;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", 64'({bus.bin, bus.busy, bus.done, bus.overflow, bus.invalid}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) bad++;
        end
        chk("midrst idle", 64'(bad), 64'd0);
        model(40'h0000000999, eb, eo, ei);
        conv_check(40'h0000000999, "after_rst");
        chk("after_rst model", 64'(bus.bin), 64'(eb));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
